// File: rtl/control_unit.sv
// control_unit: RV32I instruction decoder for the ID stage.
// Decodes opcode/funct3 into memory, writeback, branch/jump, operand-select
// and ALU-operation controls, registered once toward the ID/EX boundary.
module control_unit (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [2:0] funct,
  input  logic [6:0] opcode,
  output logic       ID_cntl_MemWrite,
  output logic       ID_cntl_MemRead,
  output logic       ID_cntl_RegWrite,
  output logic       ID_cntl_Branch,
  output logic [2:0] ID_sel_MemToReg,
  output logic [1:0] ID_sel_ALUSrc,
  output logic [1:0] ID_sel_jump,
  output logic [3:0] ID_ALUOp
);

  // Major opcodes recognised by this decoder; anything else decodes to NOP.
  typedef enum logic [6:0] {
    OP_LOAD   = 7'b0000011,
    OP_IALU   = 7'b0010011,
    OP_AUIPC  = 7'b0010111,
    OP_STORE  = 7'b0100011,
    OP_RTYPE  = 7'b0110011,
    OP_LUI    = 7'b0110111,
    OP_BRANCH = 7'b1100011,
    OP_JALR   = 7'b1100111,
    OP_JAL    = 7'b1101111
  } opcode_e;

  // Writeback source; codes 011-111 are reserved and never produced.
  typedef enum logic [2:0] {
    WB_ALU = 3'b000,
    WB_MEM = 3'b001,
    WB_PC4 = 3'b010
  } wb_sel_e;

  // ALU operand pair selection.
  typedef enum logic [1:0] {
    SRC_RS1_RS2  = 2'b00,
    SRC_RS1_IMM  = 2'b01,
    SRC_PC_IMM   = 2'b10,
    SRC_ZERO_IMM = 2'b11
  } alu_src_e;

  // Jump kind; code 11 is never produced.
  typedef enum logic [1:0] {
    JMP_NONE = 2'b00,
    JMP_JAL  = 2'b01,
    JMP_JALR = 2'b10
  } jump_e;

  // Full control bundle carried across the ID/EX boundary.
  typedef struct packed {
    logic     mem_write;
    logic     mem_read;
    logic     reg_write;
    logic     branch;
    wb_sel_e  mem_to_reg;
    alu_src_e alu_src;
    jump_e    jump;
    logic [3:0] alu_op;  // {class bit, funct3}; 0000 means plain ADD
  } ctrl_t;

  localparam ctrl_t CTRL_NOP = '{
    mem_write:  1'b0,
    mem_read:   1'b0,
    reg_write:  1'b0,
    branch:     1'b0,
    mem_to_reg: WB_ALU,
    alu_src:    SRC_RS1_RS2,
    jump:       JMP_NONE,
    alu_op:     4'b0000
  };

  ctrl_t ctrl_d;
  ctrl_t ctrl_q;

  // Combinational decode of the instruction currently in ID.
  always_comb begin
    // NOTE: start from the NOP bundle so every field has a value on every
    // path; an unassigned field on some opcode would otherwise infer a latch.
    ctrl_d = CTRL_NOP;
    case (opcode_e'(opcode))
      OP_LOAD: begin
        ctrl_d.mem_read   = 1'b1;
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = WB_MEM;
        ctrl_d.alu_src    = SRC_RS1_IMM;
      end
      OP_IALU: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = SRC_RS1_IMM;
        ctrl_d.alu_op     = {1'b0, funct};
      end
      OP_STORE: begin
        ctrl_d.mem_write  = 1'b1;
        ctrl_d.alu_src    = SRC_RS1_IMM;
      end
      OP_RTYPE: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = SRC_RS1_RS2;
        ctrl_d.alu_op     = {1'b1, funct};
      end
      OP_BRANCH: begin
        // Comparison type rides in funct3; ALU control ignores funct7 here.
        ctrl_d.branch     = 1'b1;
        ctrl_d.alu_src    = SRC_RS1_RS2;
        ctrl_d.alu_op     = {1'b1, funct};
      end
      OP_JALR: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = WB_PC4;
        ctrl_d.alu_src    = SRC_RS1_IMM;
        ctrl_d.jump       = JMP_JALR;
      end
      OP_JAL: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.mem_to_reg = WB_PC4;
        ctrl_d.alu_src    = SRC_PC_IMM;
        ctrl_d.jump       = JMP_JAL;
      end
      OP_LUI: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = SRC_ZERO_IMM;
      end
      OP_AUIPC: begin
        ctrl_d.reg_write  = 1'b1;
        ctrl_d.alu_src    = SRC_PC_IMM;
      end
      default: ctrl_d = CTRL_NOP;  // FENCE, SYSTEM and illegal encodings
    endcase
  end

  // Control register toward ID/EX; reset forces the NOP bundle at once.
  always_ff @(posedge clk or negedge rst_n) begin
    // NOTE: sequential state uses non-blocking assignment so every flop
    // samples pre-edge values regardless of block ordering.
    if (!rst_n) ctrl_q <= CTRL_NOP;
    else        ctrl_q <= ctrl_d;
  end

  assign ID_cntl_MemWrite = ctrl_q.mem_write;
  assign ID_cntl_MemRead  = ctrl_q.mem_read;
  assign ID_cntl_RegWrite = ctrl_q.reg_write;
  assign ID_cntl_Branch   = ctrl_q.branch;
  assign ID_sel_MemToReg  = ctrl_q.mem_to_reg;
  assign ID_sel_ALUSrc    = ctrl_q.alu_src;
  assign ID_sel_jump      = ctrl_q.jump;
  assign ID_ALUOp         = ctrl_q.alu_op;

endmodule

// File: tb/tb_control_unit.sv
// tb_control_unit: directed and randomized checks of control_unit against a
// table-driven reference of the RV32I decode.
module tb_control_unit;

  logic       clk;
  logic       rst_n;
  logic [2:0] funct;
  logic [6:0] opcode;
  logic       mem_write, mem_read, reg_write, branch;
  logic [2:0] mem_to_reg;
  logic [1:0] alu_src, jump;
  logic [3:0] alu_op;

  int total = 0;
  int bad   = 0;

  control_unit dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .funct            (funct),
    .opcode           (opcode),
    .ID_cntl_MemWrite (mem_write),
    .ID_cntl_MemRead  (mem_read),
    .ID_cntl_RegWrite (reg_write),
    .ID_cntl_Branch   (branch),
    .ID_sel_MemToReg  (mem_to_reg),
    .ID_sel_ALUSrc    (alu_src),
    .ID_sel_jump      (jump),
    .ID_ALUOp         (alu_op)
  );

  // Free-running clock, posedge at 5, 15, 25 ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Observed bundle packed in table order:
  // {MemWrite, MemRead, RegWrite, Branch, MemToReg, ALUSrc, jump, ALUOp}
  logic [14:0] outs;
  assign outs = {mem_write, mem_read, reg_write, branch,
                 mem_to_reg, alu_src, jump, alu_op};

  // Reference decode: one row per opcode, funct merged into ALUOp low bits
  // only for the three opcodes whose ALU operation depends on it.
  function automatic logic [14:0] model(input logic [6:0] op, input logic [2:0] f);
    logic [14:0] row;
    logic        uses_funct;
    uses_funct = 1'b0;
    case (op)
      7'b0000011: row = {4'b0110, 3'b001, 2'b01, 2'b00, 4'b0000};
      7'b0010011: begin row = {4'b0010, 3'b000, 2'b01, 2'b00, 4'b0000}; uses_funct = 1'b1; end
      7'b0100011: row = {4'b1000, 3'b000, 2'b01, 2'b00, 4'b0000};
      7'b0110011: begin row = {4'b0010, 3'b000, 2'b00, 2'b00, 4'b1000}; uses_funct = 1'b1; end
      7'b1100011: begin row = {4'b0001, 3'b000, 2'b00, 2'b00, 4'b1000}; uses_funct = 1'b1; end
      7'b1100111: row = {4'b0010, 3'b010, 2'b01, 2'b10, 4'b0000};
      7'b1101111: row = {4'b0010, 3'b010, 2'b10, 2'b01, 4'b0000};
      7'b0110111: row = {4'b0010, 3'b000, 2'b11, 2'b00, 4'b0000};
      7'b0010111: row = {4'b0010, 3'b000, 2'b10, 2'b00, 4'b0000};
      default:    row = 15'b0;
    endcase
    if (uses_funct) row[2:0] = f;
    return row;
  endfunction

  task automatic check(input string tag, input logic [14:0] observed,
                       input logic [14:0] expected);
    total++;
    assert (observed === expected)
      else begin
        bad++;
        $error("FAIL %s: observed=%b expected=%b", tag, observed, expected);
      end
  endtask

  // Drive fields between edges, let one rising edge pass, sample at negedge.
  task automatic step(input string tag, input logic [6:0] op, input logic [2:0] f);
    opcode = op;
    funct  = f;
    @(posedge clk);
    @(negedge clk);
    check(tag, outs, model(op, f));
  endtask

  logic [6:0] legal_ops [9] = '{7'b0000011, 7'b0010011, 7'b0100011,
                                7'b0110011, 7'b1100011, 7'b1100111,
                                7'b1101111, 7'b0110111, 7'b0010111};

  initial begin
    logic [6:0] op;
    logic [2:0] f;

    rst_n  = 1'b0;
    opcode = 7'b0110011;
    funct  = 3'b000;

    // Reset held across several edges keeps the NOP bundle.
    repeat (3) @(negedge clk);
    check("reset_hold", outs, 15'b0);

    // Release and take one edge: R-type ADD.
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("reset_release", outs, {4'b0010, 3'b000, 2'b00, 2'b00, 4'b1000});

    step("load",       7'b0000011, 3'b000);
    check("load_const", outs, {4'b0110, 3'b001, 2'b01, 2'b00, 4'b0000});
    step("store",      7'b0100011, 3'b000);
    step("ialu_f0",    7'b0010011, 3'b000);
    step("ialu_f1",    7'b0010011, 3'b001);
    check("ialu_f1_const", outs, {4'b0010, 3'b000, 2'b01, 2'b00, 4'b0001});
    step("rtype_f0",   7'b0110011, 3'b000);
    step("branch_f0",  7'b1100011, 3'b000);
    step("branch_f6",  7'b1100011, 3'b110);
    check("branch_f6_const", outs, {4'b0001, 3'b000, 2'b00, 2'b00, 4'b1110});
    step("jalr",       7'b1100111, 3'b101);
    step("jal",        7'b1101111, 3'b011);
    step("lui",        7'b0110111, 3'b111);
    step("auipc",      7'b0010111, 3'b010);
    step("system",     7'b1110011, 3'b000);
    step("fence",      7'b0001111, 3'b000);

    // Latency: a change between edges is invisible until the next edge.
    step("lat_before", 7'b0000011, 3'b000);
    opcode = 7'b1101111;
    #2;
    check("lat_hold", outs, model(7'b0000011, 3'b000));
    @(posedge clk);
    @(negedge clk);
    check("lat_after", outs, model(7'b1101111, 3'b000));

    // Asynchronous reset mid-stream clears without a clock edge.
    step("pre_async", 7'b0110011, 3'b100);
    #2 rst_n = 1'b0;
    #1;
    check("async_clear", outs, 15'b0);
    @(posedge clk);
    @(negedge clk);
    check("async_hold", outs, 15'b0);
    rst_n = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("async_release", outs, model(7'b0110011, 3'b100));

    // Randomized: mix of legal opcodes and arbitrary 7-bit values.
    for (int i = 0; i < 300; i++) begin
      if ($urandom_range(0, 1) == 0) op = legal_ops[$urandom_range(0, 8)];
      else                           op = 7'($urandom);
      f = 3'($urandom);
      step("random", op, f);
      check("rd_wr_exclusive", {14'b0, mem_read & mem_write}, 15'b0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Safety bound so the run always terminates.
  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded its time budget");
    $fatal(1, "timeout");
  end

endmodule
